command_framer: RTL

- Sits directly downstream of the command controller.
- Receives a serial command word on `command_1`, framed by a one-cycle `start` strobe, and stores it in a shift register.
- Retransmits the word as an asynchronous line frame on `tx_line`: start bit, data LSB first, stop bit.
- Drives `ready_command` back to the controller, so only one command is in flight at a time.

---
 rtl/command_pkg.sv | 6 +
 rtl/command_framer_bit_timer.sv | 16 +
 rtl/command_framer.sv | 105 ++++++++++
 3 files changed

// File: rtl/command_pkg.sv
// command_pkg: framer state encoding and line levels.
package command_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, START_BIT, DATA, PARITY, STOP} state_t;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
endpackage

// File: rtl/command_framer_bit_timer.sv
// bit_timer: counts clk cycles within a line bit; tick marks the last cycle of each bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  logic [CNT_W-1:0] cnt;
  assign tick = en && (cnt == CNT_W'(CLKS_PER_BIT - 1));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/command_framer.sv
// command_framer: captures a serial command and retransmits it as a start/data/stop line frame.
// Define COMMAND_FRAMER_PARITY_EN to insert an even-parity bit before the stop bit.
module command_framer
  import command_pkg::*;
#(
  parameter int CMD_BITS = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                command_1,
  output logic                ready_command,
  output logic                tx_line,
  output logic                frame_done,
  output logic [CMD_BITS-1:0] cmd_word
);
  localparam int IDX_W = (CMD_BITS > 1) ? $clog2(CMD_BITS) : 1;
  state_t state, state_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [CMD_BITS-1:0] sh, sh_d, cmd_word_d;
  logic tx_d, ready_d, done_d, tick, en, last;
  assign en = state inside {START_BIT, DATA, PARITY, STOP};
  assign last = idx == IDX_W'(CMD_BITS - 1);
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst(rst), .en(en), .tick(tick)
  );
  // sh doubles as capture register and transmit shifter; tx_line shows sh[0] during DATA
  always_comb begin
    state_d = state;
    idx_d = idx;
    sh_d = sh;
    cmd_word_d = cmd_word;
    tx_d = tx_line;
    ready_d = ready_command;
    done_d = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_d = CAPTURE;
        ready_d = 1'b0;
        idx_d = '0;
      end
      CAPTURE: begin
        sh_d = {command_1, sh[CMD_BITS-1:1]};
        idx_d = idx + 1'b1;
        if (last) begin
          cmd_word_d = sh_d;
          state_d = START_BIT;
          tx_d = START_LVL;
          idx_d = '0;
        end
      end
      START_BIT: if (tick) begin
        state_d = DATA;
        tx_d = sh[0];
      end
      DATA: if (tick) begin
        sh_d = sh >> 1;
        idx_d = idx + 1'b1;
        tx_d = sh[1];
        if (last) begin
          idx_d = '0;
`ifdef COMMAND_FRAMER_PARITY_EN
          state_d = PARITY;
          tx_d = ^cmd_word;
`else
          state_d = STOP;
          tx_d = IDLE_LVL;
`endif
        end
      end
`ifdef COMMAND_FRAMER_PARITY_EN
      PARITY: if (tick) begin
        state_d = STOP;
        tx_d = IDLE_LVL;
      end
`endif
      STOP: if (tick) begin
        state_d = IDLE;
        ready_d = 1'b1;
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      sh <= '0;
      cmd_word <= '0;
      tx_line <= IDLE_LVL;
      ready_command <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      sh <= sh_d;
      cmd_word <= cmd_word_d;
      tx_line <= tx_d;
      ready_command <= ready_d;
      frame_done <= done_d;
    end
endmodule
